// File: rtl/ff_ctrl_pkg.sv
// ff_ctrl_pkg: shared types and the per-bit excitation helper for the
// SR-bank arbiter.
//   mode_t    - requested flip-flop behaviour (SR, JK, D, T)
//   state_t   - controller sequencing states
//   excite_t  - one bit's {s, r, err} excitation result
//   sr_excite - converts one bit's mode/operands/current q into legal S/R
package ff_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_SR = 2'b00,
        MODE_JK = 2'b01,
        MODE_D  = 2'b10,
        MODE_T  = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_EXCITE = 2'b01,
        ST_APPLY  = 2'b10,
        ST_RESP   = 2'b11
    } state_t;

    typedef struct packed {
        logic s;
        logic r;
        logic err;
    } excite_t;

    // An SR request with S=R=1 is turned into a hold and flagged, so the
    // bank itself never sees the forbidden input combination.
    function automatic excite_t sr_excite(mode_t mode, logic a, logic b, logic q);
        excite_t e;
        e = '0;
        case (mode)
            MODE_SR: begin
                if (a && b) begin
                    e.err = 1'b1;
                end else begin
                    e.s = a;
                    e.r = b;
                end
            end
            MODE_JK: begin
                e.s = a & ~q;
                e.r = b & q;
            end
            MODE_D: begin
                e.s = a;
                e.r = ~a;
            end
            MODE_T: begin
                e.s = a & ~q;
                e.r = a & q;
            end
            default: e = '0;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/srff_bank.sv
// srff_bank: W independent SR flip-flops sharing clock and async reset.
//   clk, rst - clock and asynchronous active-high reset (q clears to 0)
//   s, r     - per-bit set / reset excitation, applied every rising edge
//   q        - current bank state
module srff_bank #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] s,
    input  logic [W-1:0] r,
    output logic [W-1:0] q
);

    // 10 sets, 01 clears, 00 holds; 11 is treated as hold so the bank can
    // never be driven to an undefined value even if a caller misbehaves.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else begin
            q <= (q & ~(r & ~s)) | (s & ~r);
        end
    end

endmodule

// File: rtl/sr_bank_arbiter.sv
// sr_bank_arbiter: round-robin front end for two requesters sharing one
// W-bit SR flip-flop bank. Each operation runs IDLE -> EXCITE -> APPLY -> RESP.
//   clk, rst                 - clock, asynchronous active-high reset
//   reqN_valid / reqN_ready  - request handshake (ready only in IDLE)
//   reqN_mode/mask/a/b       - requested mode, bit mask and operands
//   rsp_valid / rsp_ready    - response handshake
//   rsp_id, rsp_q, rsp_err   - owner, post-operation state, illegal-SR bits
//   q_out                    - live bank state
//   err_count                - saturating count of responses with errors
module sr_bank_arbiter
    import ff_ctrl_pkg::*;
#(
    parameter int W    = 4,
    parameter int ERRW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [1:0]      req0_mode,
    input  logic [W-1:0]    req0_mask,
    input  logic [W-1:0]    req0_a,
    input  logic [W-1:0]    req0_b,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [1:0]      req1_mode,
    input  logic [W-1:0]    req1_mask,
    input  logic [W-1:0]    req1_a,
    input  logic [W-1:0]    req1_b,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic            rsp_id,
    output logic [W-1:0]    rsp_q,
    output logic [W-1:0]    rsp_err,
    output logic [W-1:0]    q_out,
    output logic [ERRW-1:0] err_count
);

    state_t       state;
    logic         last_grant;
    logic         grant0;
    logic         grant1;
    mode_t        op_mode;
    logic [W-1:0] op_mask;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         op_id;
    logic [W-1:0] s_reg;
    logic [W-1:0] r_reg;
    logic [W-1:0] err_reg;
    logic [W-1:0] exc_s;
    logic [W-1:0] exc_r;
    logic [W-1:0] exc_err;
    logic [W-1:0] q_next;

    // last_grant = 1 means req1 was served last, so req0 wins the next tie.
    // Grants are suppressed while reset is held so ready reads 0 in reset.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == ST_IDLE && !rst) begin
            if (req0_valid && (!req1_valid || last_grant)) begin
                grant0 = 1'b1;
            end else if (req1_valid) begin
                grant1 = 1'b1;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_comb begin
        excite_t e;
        exc_s   = '0;
        exc_r   = '0;
        exc_err = '0;
        for (int i = 0; i < W; i++) begin
            e          = sr_excite(op_mode, op_a[i], op_b[i], q_out[i]);
            exc_s[i]   = e.s   & op_mask[i];
            exc_r[i]   = e.r   & op_mask[i];
            exc_err[i] = e.err & op_mask[i];
        end
    end

    // State the bank will hold after the APPLY edge, captured into rsp_q.
    assign q_next = (q_out & ~(r_reg & ~s_reg)) | (s_reg & ~r_reg);

    srff_bank #(.W(W)) u_bank (
        .clk (clk),
        .rst (rst),
        .s   (s_reg),
        .r   (r_reg),
        .q   (q_out)
    );

    // s_reg/r_reg are nonzero only for the single APPLY cycle, so the bank
    // changes on exactly one edge per operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            last_grant <= 1'b1;
            op_mode    <= MODE_SR;
            op_mask    <= '0;
            op_a       <= '0;
            op_b       <= '0;
            op_id      <= 1'b0;
            s_reg      <= '0;
            r_reg      <= '0;
            err_reg    <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_q      <= '0;
            rsp_err    <= '0;
            err_count  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant0) begin
                        op_mode    <= mode_t'(req0_mode);
                        op_mask    <= req0_mask;
                        op_a       <= req0_a;
                        op_b       <= req0_b;
                        op_id      <= 1'b0;
                        last_grant <= 1'b0;
                        state      <= ST_EXCITE;
                    end else if (grant1) begin
                        op_mode    <= mode_t'(req1_mode);
                        op_mask    <= req1_mask;
                        op_a       <= req1_a;
                        op_b       <= req1_b;
                        op_id      <= 1'b1;
                        last_grant <= 1'b1;
                        state      <= ST_EXCITE;
                    end
                end
                ST_EXCITE: begin
                    s_reg   <= exc_s;
                    r_reg   <= exc_r;
                    err_reg <= exc_err;
                    state   <= ST_APPLY;
                end
                ST_APPLY: begin
                    s_reg     <= '0;
                    r_reg     <= '0;
                    rsp_valid <= 1'b1;
                    rsp_id    <= op_id;
                    rsp_q     <= q_next;
                    rsp_err   <= err_reg;
                    if ((|err_reg) && (err_count != '1)) begin
                        err_count <= err_count + ERRW'(1);
                    end
                    state <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sr_bank_arbiter.sv
// tb_sr_bank_arbiter: table-driven, hand-written and randomized checks of
// sr_bank_arbiter against a next-state (characteristic equation) model.
module tb_sr_bank_arbiter;

    localparam int W    = 4;
    localparam int ERRW = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            req0_valid = 1'b0;
    logic            req0_ready;
    logic [1:0]      req0_mode = '0;
    logic [W-1:0]    req0_mask = '0;
    logic [W-1:0]    req0_a = '0;
    logic [W-1:0]    req0_b = '0;
    logic            req1_valid = 1'b0;
    logic            req1_ready;
    logic [1:0]      req1_mode = '0;
    logic [W-1:0]    req1_mask = '0;
    logic [W-1:0]    req1_a = '0;
    logic [W-1:0]    req1_b = '0;
    logic            rsp_valid;
    logic            rsp_ready = 1'b0;
    logic            rsp_id;
    logic [W-1:0]    rsp_q;
    logic [W-1:0]    rsp_err;
    logic [W-1:0]    q_out;
    logic [ERRW-1:0] err_count;

    sr_bank_arbiter #(.W(W), .ERRW(ERRW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_mode  (req0_mode),
        .req0_mask  (req0_mask),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_mode  (req1_mode),
        .req1_mask  (req1_mask),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_q      (rsp_q),
        .rsp_err    (rsp_err),
        .q_out      (q_out),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]   mode;
        logic [W-1:0] mask;
        logic [W-1:0] a;
        logic [W-1:0] b;
    } req_t;

    typedef struct {
        bit           id;
        logic [1:0]   mode;
        logic [W-1:0] mask;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_q;
        logic [W-1:0] exp_err;
    } vec_t;

    int errors = 0;
    int checks = 0;
    int sr_bad = 0;

    logic [W-1:0] model_q    = '0;
    bit           model_last = 1'b1;
    int           model_errs = 0;

    // The bank must never be driven with S and R both high.
    always @(negedge clk) begin
        if ((dut.u_bank.s & dut.u_bank.r) != '0) sr_bad++;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Next state from the flip-flop characteristic equations.
    function automatic void model_op(input logic [1:0] mode, input logic [W-1:0] mask,
                                     input logic [W-1:0] a, input logic [W-1:0] b,
                                     input logic [W-1:0] q,
                                     output logic [W-1:0] nq, output logic [W-1:0] err);
        nq  = q;
        err = '0;
        for (int i = 0; i < W; i++) begin
            if (mask[i]) begin
                case (mode)
                    2'd0: begin
                        if (a[i] && b[i]) err[i] = 1'b1;
                        else if (a[i])    nq[i] = 1'b1;
                        else if (b[i])    nq[i] = 1'b0;
                    end
                    2'd1: nq[i] = (a[i] & ~q[i]) | (~b[i] & q[i]);
                    2'd2: nq[i] = a[i];
                    default: nq[i] = a[i] ^ q[i];
                endcase
            end
        end
    endfunction

    // One full operation: request, grant, 3-cycle latency, optional
    // backpressure, response handshake.
    task automatic applyStimulus(input bit v0, input bit v1, input req_t r0, input req_t r1,
                                 input int bp, output logic gid,
                                 output logic [W-1:0] gq, output logic [W-1:0] gerr);
        int           g;
        int           k;
        req_t         rg;
        logic [W-1:0] eq;
        logic [W-1:0] ee;
        req0_mode = r0.mode; req0_mask = r0.mask; req0_a = r0.a; req0_b = r0.b;
        req1_mode = r1.mode; req1_mask = r1.mask; req1_a = r1.a; req1_b = r1.b;
        req0_valid = v0;
        req1_valid = v1;
        rsp_ready  = 1'b0;
        #1;
        g = (v0 && v1) ? (model_last ? 0 : 1) : (v0 ? 0 : 1);
        checkOutput("req0_ready grant", {31'd0, req0_ready}, (g == 0) ? 32'd1 : 32'd0);
        checkOutput("req1_ready grant", {31'd0, req1_ready}, (g == 1) ? 32'd1 : 32'd0);
        @(posedge clk);
        @(negedge clk);
        model_last = (g == 1);
        rg = (g == 0) ? r0 : r1;
        model_op(rg.mode, rg.mask, rg.a, rg.b, model_q, eq, ee);
        model_q = eq;
        if (ee != '0 && model_errs < 255) model_errs++;
        k = 1;
        while (!rsp_valid && k < 10) begin
            checkOutput("ready low while busy", {30'd0, req0_ready, req1_ready}, 32'd0);
            @(negedge clk);
            k++;
        end
        checkOutput("response latency", k, 3);
        gid  = rsp_id;
        gq   = rsp_q;
        gerr = rsp_err;
        checkOutput("rsp_id", {31'd0, rsp_id}, g);
        checkOutput("rsp_q", {28'd0, rsp_q}, {28'd0, eq});
        checkOutput("rsp_err", {28'd0, rsp_err}, {28'd0, ee});
        checkOutput("q_out", {28'd0, q_out}, {28'd0, eq});
        checkOutput("err_count", {24'd0, err_count}, model_errs);
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            checkOutput("bp rsp_valid", {31'd0, rsp_valid}, 32'd1);
            checkOutput("bp rsp_id stable", {31'd0, rsp_id}, {31'd0, gid});
            checkOutput("bp rsp_q stable", {28'd0, rsp_q}, {28'd0, gq});
            checkOutput("bp rsp_err stable", {28'd0, rsp_err}, {28'd0, gerr});
            checkOutput("bp q_out stable", {28'd0, q_out}, {28'd0, eq});
            checkOutput("bp ready low", {30'd0, req0_ready, req1_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready  = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        checkOutput("rsp_valid after handshake", {31'd0, rsp_valid}, 32'd0);
        checkOutput("q_out after handshake", {28'd0, q_out}, {28'd0, eq});
    endtask

    initial begin
        vec_t         tab[8];
        req_t         ra;
        req_t         rb;
        logic         gid;
        logic [W-1:0] gq;
        logic [W-1:0] gerr;

        //            id mode  mask   a      b      exp_q  exp_err
        tab[0] = '{1'b0, 2'd2, 4'hF, 4'hA, 4'h0, 4'hA, 4'h0};
        tab[1] = '{1'b1, 2'd1, 4'hF, 4'hF, 4'hF, 4'h5, 4'h0};
        tab[2] = '{1'b0, 2'd0, 4'h3, 4'h3, 4'h1, 4'h7, 4'h1};
        tab[3] = '{1'b1, 2'd3, 4'hF, 4'h6, 4'h0, 4'h1, 4'h0};
        tab[4] = '{1'b0, 2'd2, 4'hC, 4'h0, 4'h0, 4'h1, 4'h0};
        tab[5] = '{1'b1, 2'd0, 4'hF, 4'h8, 4'h1, 4'h8, 4'h0};
        tab[6] = '{1'b0, 2'd1, 4'h5, 4'h4, 4'h5, 4'hC, 4'h0};
        tab[7] = '{1'b1, 2'd2, 4'h3, 4'hF, 4'h0, 4'hF, 4'h0};

        // Reset with both requesters asserting valid: nothing may be granted.
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("reset q_out", {28'd0, q_out}, 32'd0);
        checkOutput("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
        checkOutput("reset ready", {30'd0, req0_ready, req1_ready}, 32'd0);
        checkOutput("reset err_count", {24'd0, err_count}, 32'd0);
        checkOutput("reset rsp_q", {28'd0, rsp_q}, 32'd0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);

        // Directed vectors, one requester at a time.
        for (int i = 0; i < 8; i++) begin
            ra = '{tab[i].mode, tab[i].mask, tab[i].a, tab[i].b};
            applyStimulus(!tab[i].id, tab[i].id, ra, ra, (i == 2) ? 1 : 0, gid, gq, gerr);
            checkOutput("table rsp_id", {31'd0, gid}, {31'd0, tab[i].id});
            checkOutput("table rsp_q", {28'd0, gq}, {28'd0, tab[i].exp_q});
            checkOutput("table rsp_err", {28'd0, gerr}, {28'd0, tab[i].exp_err});
        end
        checkOutput("table err_count", {24'd0, err_count}, 32'd1);

        // Contention: both valid for four operations, alternating grants,
        // with a long backpressure stall on the second response.
        ra = '{2'd2, 4'hF, 4'h3, 4'h0};
        rb = '{2'd2, 4'hF, 4'hC, 4'h0};
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 1'b1, ra, rb, (k == 1) ? 5 : 0, gid, gq, gerr);
            checkOutput("contention grant order", {31'd0, gid}, k % 2);
        end

        // Reset during APPLY of a D write of all ones: dropped, bank cleared.
        req0_mode = 2'd2; req0_mask = 4'hF; req0_a = 4'hF; req0_b = 4'h0;
        req0_valid = 1'b1;
        #1;
        checkOutput("midop req0_ready", {31'd0, req0_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("midop q_out", {28'd0, q_out}, 32'd0);
        checkOutput("midop rsp_valid", {31'd0, rsp_valid}, 32'd0);
        checkOutput("midop err_count", {24'd0, err_count}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_q    = '0;
        model_last = 1'b1;
        model_errs = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("post-reset no response", {31'd0, rsp_valid}, 32'd0);
            checkOutput("post-reset q_out", {28'd0, q_out}, 32'd0);
        end
        ra = '{2'd2, 4'hF, 4'h9, 4'h0};
        rb = '{2'd2, 4'hF, 4'h6, 4'h0};
        applyStimulus(1'b1, 1'b1, ra, rb, 0, gid, gq, gerr);
        checkOutput("post-reset req0 wins", {31'd0, gid}, 32'd0);
        checkOutput("post-reset rsp_q", {28'd0, gq}, 32'h9);

        // Randomized operations against the model.
        for (int n = 0; n < 60; n++) begin
            int p;
            p  = $urandom_range(0, 2);
            ra = '{2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                   4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))};
            rb = '{2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                   4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))};
            applyStimulus(p != 1, p != 0, ra, rb, $urandom_range(0, 2), gid, gq, gerr);
        end

        checkOutput("bank S=R=1 cycles", sr_bad, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sr_bank_arbiter.md
# sr_bank_arbiter

Two-requester controller that shares one W-bit bank of SR flip-flops. Each request is a mode (SR, JK, D or T) with per-bit operands. The block grants requesters round-robin and converts the requested mode into legal S/R excitations from the current bank state. It then applies one clock edge to the bank and returns the new state with a per-bit illegal-SR error vector. It is the sequencing layer above the flip-flop conversion cells.

## Interface
- W, default 4: bank width in bits.
- ERRW, default 8: width of the saturating error counter.

- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous reset, active-high.
- req0_valid, req1_valid  input  1 each  request pending.
- req0_ready, req1_ready  output  1 each  grant; handshake when valid and ready are both high at a rising edge.
- req0_mode, req1_mode  input  2 each  00 SR, 01 JK, 10 D, 11 T.
- req0_mask, req1_mask  input  W each  bits to operate on; a 0 bit is held.
- req0_a, req1_a  input  W each  S / J / D / T operand.
- req0_b, req1_b  input  W each  R / K operand; ignored in D and T modes.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  response consumer ready.
- rsp_id  output  1  requester that owns the response.
- rsp_q  output  W  bank state after the operation.
- rsp_err  output  W  bits where SR mode had S=R=1.
- q_out  output  W  live bank state.
- err_count  output  ERRW  number of responses with rsp_err≠0; saturates at all-ones.

## Operation
- States: IDLE, EXCITE, APPLY, RESP.
- IDLE:
  - Arbiter grants one valid requester; ready is asserted combinationally to that requester only.
  - Round-robin: on contention, grant the requester not granted last. After reset, req0 wins first contention.
  - On handshake, latch mode, mask, a, b and id, then go to EXCITE.
- EXCITE: register per-bit s and r from the latched operands and current q, then go to APPLY.
  - Masked-off bits: s=0, r=0.
  - SR mode: s=a, r=b. If a=b=1, force s=r=0 (bit holds) and set the err bit.
  - JK mode: s=a&~q, r=b&q.
  - D mode: s=a, r=~a.
  - T mode: s=a&~q, r=a&q.
- APPLY: the bank updates on this edge (00 hold, 10 set, 01 clear; 11 never reaches the bank). Go to RESP.
- RESP:
  - rsp_valid=1; rsp_id, rsp_q and rsp_err are stable until the rsp handshake.
  - err_count increments once per response with a nonzero err vector.
  - On handshake, return to IDLE.
- req*_ready is 0 outside IDLE. The bank never sees S=R=1 and never holds X.

## Timing
- Reset values: q_out=0, rsp_valid=0, rsp_id=0, rsp_q=0, rsp_err=0, err_count=0, req*_ready=0, state IDLE, last-grant pointer = req1.
- Latency: request accepted at edge E0 → excitation registered at E1 → bank updated at E2 → rsp_valid high in the cycle after E2.
- Minimum initiation interval: 4 cycles per operation, because IDLE always lasts at least one cycle.
- Backpressure: if rsp_ready is low, stay in RESP indefinitely with outputs frozen. q_out does not change.
- Simultaneous valid on both requesters: exactly one grant per IDLE cycle. A requester may deassert valid before it is granted without side effects.
- Reset asserted in any state: immediate return to IDLE. The in-flight operation is dropped with no response, q_out=0, and err_count=0.

## Structure
- Package ff_ctrl_pkg holds:
  - mode enum: MODE_SR, MODE_JK, MODE_D, MODE_T;
  - state enum;
  - function sr_excite(mode, a, b, q) returning {s, r, err} per bit.
- Sub-module srff_bank: W parallel SR flip-flops with async reset, an enable-free s/r vector and a q vector. The controller instantiates it once.

## Test plan
- Reset: hold rst high for 2 cycles → q_out=0, rsp_valid=0, both ready=0, err_count=0.
- D write: req0 D, mask=F, a=A → rsp_valid 3 cycles after accept, rsp_id=0, rsp_q=A, rsp_err=0.
- JK toggle: with q=A, req1 JK, mask=F, a=F, b=F → rsp_q=5, rsp_id=1.
- SR illegal: with q=5, req0 SR, mask=3, a=3, b=1 → rsp_q=7, rsp_err=1, err_count=1. Bank S/R never both high.
- Arbitration and backpressure: both valid for 4 operations → grant order 0,1,0,1. Hold rsp_ready low 5 cycles on one response → outputs stable, req*_ready=0 throughout.
- Reset mid-op: assert rst during APPLY of a D write a=F → q_out=0, no response. Next request is served normally, and req0 wins contention.
